cc_branch_ctrl: RTL
===================

Name: cc_branch_ctrl

Overview:
Owns the LC-3 condition-code register and sequences conditional-branch resolution for the control unit. It samples the data bus through an nzp_logic instance on LD_CC and holds the result in a 3-bit NZP register. On a branch request it compares IR[11:9] against NZP, and it issues a one-cycle PC-load strobe when the branch is taken. It sits between the ISDU, which raises br_start in the BR execute state and waits for br_done, and the PC mux/load path.

Parameters:
DATA_WIDTH, 16, bus and IR width; the sign bit is DATA_WIDTH-1.
RESET_NZP, 3'b010, NZP register value after reset (Z set).

Ports:
Clk  input  1  system clock; all state updates on rising edge.
Reset  input  1  synchronous, active-high reset.
LD_CC  input  1  load NZP register from bus_in this cycle.
bus_in  input  DATA_WIDTH  data bus value evaluated for condition codes.
IR  input  DATA_WIDTH  current instruction register.
br_start  input  1  request branch resolution (single-cycle pulse or level; sampled only in IDLE).
nzp_out  output  3  current NZP register {N,Z,P}.
busy  output  1  high in any state other than IDLE.
ben  output  1  registered branch-enable result of the last evaluation.
ld_pc_br  output  1  one-cycle strobe: load PC with PC+SEXT(IR[8:0]).
br_done  output  1  one-cycle completion pulse.
br_err  output  1  one-cycle pulse coincident with br_done when IR[15:12] != 4'b0000.

Behaviour:
- Reset (synchronous, Reset high at a rising edge) produces: nzp_out=RESET_NZP, state=IDLE, ben=0, ld_pc_br=0, br_done=0, br_err=0, busy=0, cond_reg=0. Reset overrides LD_CC and br_start in the same cycle.
- NZP register:
  - If LD_CC=1 at an edge, nzp <= nzp_logic(bus_in). The mapping is: sign bit set -> 100; all other bits zero (value 0) -> 010; otherwise -> 001.
  - The result is always one-hot. Otherwise the register holds.
  - LD_CC is honoured in every FSM state.
- FSM states: IDLE, EVAL, TAKE, DONE.
  - IDLE: if br_start=1, latch cond_reg<=IR[11:9] and opc_ok<=(IR[15:12]==0); go to EVAL. Otherwise stay.
  - EVAL: ben <= opc_ok & |(cond_reg & nzp). The NZP value used is the register value in this cycle, so an LD_CC in the br_start cycle is visible. An LD_CC asserted during EVAL is not visible. If the computed ben=1, go to TAKE; otherwise go to DONE.
  - TAKE: ld_pc_br=1 for this cycle only; go to DONE.
  - DONE: br_done=1 and br_err=!opc_ok for this cycle; go to IDLE.
- Outputs ld_pc_br, br_done and br_err are Moore-decoded from state and registered flags; they are never asserted combinationally from inputs.
- Latency, with br_start sampled at edge 0:
  - Taken: ld_pc_br high in the cycle after edge 1; br_done high in the cycle after edge 2.
  - Not taken: br_done high in the cycle after edge 1; ld_pc_br never asserted.
- Boundary cases:
  - br_start while busy is ignored entirely: no queuing, cond_reg unchanged.
  - br_start asserted in the DONE cycle is ignored. It is accepted on the next cycle in IDLE.
  - cond=000 is never taken (NOP). cond=111 is always taken, because NZP is one-hot.
  - Opcode != BR: ben=0, no PC load, br_err pulses with br_done.
  - ben holds its value until the next EVAL or reset.
  - Reset mid-operation (EVAL/TAKE/DONE): return to IDLE next cycle. No ld_pc_br or br_done is emitted afterwards for the aborted request.

Decomposition:
- Shared package (lc3_pkg):
  - typedef enum logic [1:0] {IDLE, EVAL, TAKE, DONE} br_state_t.
  - constant OPC_BR = 4'b0000.
  - constant NZP_RESET = 3'b010.
- One sub-module: the existing nzp_logic, instantiated for bus_in -> next NZP. The FSM and registers stay in cc_branch_ctrl.

Test Plan:
- Reset: hold Reset 2 cycles -> nzp_out=010, busy=0, ben=0; all strobes 0.
- CC load: LD_CC with bus_in=16'h8001 -> nzp_out=100 next cycle; 16'h0000 -> 010; 16'h7FFF -> 001; 16'h1234 with LD_CC=0 -> unchanged.
- BRz taken: nzp=010, IR=16'h0405, br_start pulse -> busy=1; ben=1; ld_pc_br 1 cycle at +2; br_done at +3; br_err=0.
- BRn not taken and NOP:
  - nzp=001, IR=16'h0805 -> br_done at +2, ld_pc_br never, ben=0.
  - IR=16'h0000 with any nzp -> not taken.
- LD_CC ordering and busy rejection:
  - LD_CC with bus_in=0 in the same cycle as br_start with IR=16'h0400 and prior nzp=001 -> taken.
  - br_start re-pulsed during EVAL/TAKE -> ignored, exactly one br_done.
- Error and abort:
  - IR=16'h1E00 (ADD) with br_start -> not taken; br_err=1 with br_done.
  - Reset asserted in the TAKE cycle -> IDLE next cycle, no br_done, nzp_out=010.

Source files
------------

// File: rtl/lc3_pkg.sv
// lc3_pkg: shared types and constants for the LC-3 branch/condition-code path
package lc3_pkg;
   typedef enum logic [1:0] {IDLE, EVAL, TAKE, DONE} br_state_t;
   localparam logic [3:0] OPC_BR    = 4'b0000;
   localparam logic [2:0] NZP_RESET = 3'b010;
endpackage

// File: rtl/cc_branch_ctrl_if.sv
// cc_branch_ctrl_if: condition-code load and branch handshake between ISDU and cc_branch_ctrl
interface cc_branch_ctrl_if #(parameter int DATA_WIDTH = 16);
   logic                  LD_CC;
   logic [DATA_WIDTH-1:0] bus_in;
   logic [DATA_WIDTH-1:0] IR;
   logic                  br_start;
   logic [2:0]            nzp_out;
   logic                  busy;
   logic                  ben;
   logic                  ld_pc_br;
   logic                  br_done;
   logic                  br_err;
   modport master (output LD_CC, bus_in, IR, br_start,
                   input  nzp_out, busy, ben, ld_pc_br, br_done, br_err);
   modport slave  (input  LD_CC, bus_in, IR, br_start,
                   output nzp_out, busy, ben, ld_pc_br, br_done, br_err);
endinterface

// File: rtl/nzp_logic.sv
// nzp_logic: one-hot {N,Z,P} classification of a bus value
module nzp_logic #(parameter int DATA_WIDTH = 16) (
   input  logic [DATA_WIDTH-1:0] data,
   output logic [2:0]            nzp
);
   assign nzp = data[DATA_WIDTH-1] ? 3'b100 : (data == '0) ? 3'b010 : 3'b001;
endmodule

// File: rtl/cc_branch_ctrl.sv
// cc_branch_ctrl: NZP register plus BR resolution FSM issuing the PC-load strobe
module cc_branch_ctrl
   import lc3_pkg::*;
#(
   parameter int         DATA_WIDTH = 16,
   parameter logic [2:0] RESET_NZP  = NZP_RESET
) (
   input logic              Clk,
   input logic              Reset,
   cc_branch_ctrl_if.slave  bus
);
   br_state_t  state, state_n;
   logic [2:0] nzp, nzp_n, cond_reg;
   logic       opc_ok, ben_r, ben_c;

   nzp_logic #(.DATA_WIDTH(DATA_WIDTH)) u_nzp (.data(bus.bus_in), .nzp(nzp_n));

   assign ben_c = opc_ok & |(cond_reg & nzp);

   // state, condition codes and the latched request; LD_CC is honoured in every state
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state    <= IDLE;
         nzp      <= RESET_NZP;
         cond_reg <= '0;
         opc_ok   <= 1'b0;
         ben_r    <= 1'b0;
      end else begin
         state <= state_n;
         if (bus.LD_CC) nzp <= nzp_n;
         if (state == IDLE && bus.br_start) begin
            cond_reg <= bus.IR[11:9];
            opc_ok   <= bus.IR[15:12] == OPC_BR;
         end
         if (state == EVAL) ben_r <= ben_c;
      end
   end

   // next state; requests are only accepted while idle
   always_comb begin
      state_n = state;
      state_n = (state == IDLE) ? (bus.br_start ? EVAL : IDLE) :
                (state == EVAL) ? (ben_c ? TAKE : DONE) :
                (state == TAKE) ? DONE : IDLE;
   end

   assign bus.nzp_out  = nzp;
   assign bus.busy     = state != IDLE;
   assign bus.ben      = ben_r;
   assign bus.ld_pc_br = state == TAKE;
   assign bus.br_done  = state == DONE;
   assign bus.br_err   = (state == DONE) & ~opc_ok;
endmodule
